// File: rtl/pipe_stage_buf.sv
// EX->MEM pipeline stage register with valid/ready handshake, flush and an optional skid entry.
// The head entry drives every output; control outputs are masked to zero whenever the head is empty.
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [1:0]        MEM_i,
    input  logic [DATA_W-1:0] ALUOut_i,
    input  logic [DATA_W-1:0] RTData_i,
    input  logic [REG_W-1:0]  RD_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WB_W-1:0]   WB_o,
    output logic [DATA_W-1:0] ALUOut_o,
    output logic [DATA_W-1:0] RTData_o,
    output logic [REG_W-1:0]  RD_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [1:0]        occupancy_o
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [1:0]        mem;
        logic [DATA_W-1:0] aluOut;
        logic [DATA_W-1:0] rtData;
        logic [REG_W-1:0]  rd;
    } entry_t;

    entry_t headEntry_q, headEntry_d;
    entry_t skidEntry_q, skidEntry_d;
    logic   headValid_q, headValid_d;
    logic   skidValid_q, skidValid_d;

    entry_t inEntry;
    logic   acceptIn;
    logic   releaseOut;

    assign inEntry    = '{wb: WB_i, mem: MEM_i, aluOut: ALUOut_i, rtData: RTData_i, rd: RD_i};
    // With the skid entry, ready comes straight from a flop so no combinational path reaches upstream.
    assign in_ready_o = (SKID != 0) ? ~skidValid_q : (~headValid_q | out_ready_i);
    assign acceptIn   = in_valid_i & in_ready_o;
    assign releaseOut = headValid_q & out_ready_i;

    always_comb begin
        headEntry_d = headEntry_q;
        headValid_d = headValid_q;
        skidEntry_d = skidEntry_q;
        skidValid_d = skidValid_q;

        if (SKID != 0) begin
            if (releaseOut && skidValid_q) begin
                headEntry_d = skidEntry_q;
                skidValid_d = 1'b0;
            end else if (acceptIn && (!headValid_q || releaseOut)) begin
                headEntry_d = inEntry;
                headValid_d = 1'b1;
            end else if (acceptIn) begin
                skidEntry_d = inEntry;
                skidValid_d = 1'b1;
            end else if (releaseOut) begin
                headValid_d = 1'b0;
            end
        end else begin
            if (acceptIn) begin
                headEntry_d = inEntry;
                headValid_d = 1'b1;
            end else if (releaseOut) begin
                headValid_d = 1'b0;
            end
        end

        // Flush drops any same-cycle accept and leaves the data fields untouched.
        if (flush_i) begin
            headEntry_d = headEntry_q;
            skidEntry_d = skidEntry_q;
            headValid_d = 1'b0;
            skidValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            headEntry_q <= '0;
            skidEntry_q <= '0;
            headValid_q <= 1'b0;
            skidValid_q <= 1'b0;
        end else begin
            headEntry_q <= headEntry_d;
            skidEntry_q <= skidEntry_d;
            headValid_q <= headValid_d;
            skidValid_q <= skidValid_d;
        end
    end

    assign out_valid_o = headValid_q;
    assign WB_o        = headValid_q ? headEntry_q.wb : '0;
    assign MemRead_o   = headEntry_q.mem[0] & headValid_q;
    assign MemWrite_o  = headEntry_q.mem[1] & headValid_q;
    assign ALUOut_o    = headEntry_q.aluOut;
    assign RTData_o    = headEntry_q.rtData;
    assign RD_o        = headEntry_q.rd;
    assign occupancy_o = {1'b0, headValid_q} + {1'b0, skidValid_q};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a skid instance, a single-entry instance and a wide skid instance.
module tb_pipe_stage_buf;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    int vectorCount = 0;
    int missCount   = 0;

    // SKID=1 instance, default widths
    logic        s1Flush = 0, s1InValid = 0, s1InReady, s1OutValid, s1OutReady = 0;
    logic [1:0]  s1WbIn = 0, s1MemIn = 0, s1WbOut, s1Occ;
    logic [31:0] s1AluIn = 0, s1RtIn = 0, s1AluOut, s1RtOut;
    logic [4:0]  s1RdIn = 0, s1RdOut;
    logic        s1MemRead, s1MemWrite;

    // SKID=0 instance, default widths
    logic        s0Flush = 0, s0InValid = 0, s0InReady, s0OutValid, s0OutReady = 0;
    logic [1:0]  s0WbIn = 0, s0MemIn = 0, s0WbOut, s0Occ;
    logic [31:0] s0AluIn = 0, s0RtIn = 0, s0AluOut, s0RtOut;
    logic [4:0]  s0RdIn = 0, s0RdOut;
    logic        s0MemRead, s0MemWrite;

    // SKID=1 instance, wide fields
    logic        wFlush = 0, wInValid = 0, wInReady, wOutValid, wOutReady = 0;
    logic [2:0]  wWbIn = 0, wWbOut;
    logic [1:0]  wMemIn = 0, wOcc;
    logic [63:0] wAluIn = 0, wRtIn = 0, wAluOut, wRtOut;
    logic [5:0]  wRdIn = 0, wRdOut;
    logic        wMemRead, wMemWrite;

    pipe_stage_buf #(.DATA_W(32), .REG_W(5), .WB_W(2), .SKID(1)) dutSkid (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(s1Flush),
        .in_valid_i(s1InValid), .in_ready_o(s1InReady),
        .WB_i(s1WbIn), .MEM_i(s1MemIn), .ALUOut_i(s1AluIn), .RTData_i(s1RtIn), .RD_i(s1RdIn),
        .out_valid_o(s1OutValid), .out_ready_i(s1OutReady),
        .WB_o(s1WbOut), .ALUOut_o(s1AluOut), .RTData_o(s1RtOut), .RD_o(s1RdOut),
        .MemRead_o(s1MemRead), .MemWrite_o(s1MemWrite), .occupancy_o(s1Occ));

    pipe_stage_buf #(.DATA_W(32), .REG_W(5), .WB_W(2), .SKID(0)) dutSingle (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(s0Flush),
        .in_valid_i(s0InValid), .in_ready_o(s0InReady),
        .WB_i(s0WbIn), .MEM_i(s0MemIn), .ALUOut_i(s0AluIn), .RTData_i(s0RtIn), .RD_i(s0RdIn),
        .out_valid_o(s0OutValid), .out_ready_i(s0OutReady),
        .WB_o(s0WbOut), .ALUOut_o(s0AluOut), .RTData_o(s0RtOut), .RD_o(s0RdOut),
        .MemRead_o(s0MemRead), .MemWrite_o(s0MemWrite), .occupancy_o(s0Occ));

    pipe_stage_buf #(.DATA_W(64), .REG_W(6), .WB_W(3), .SKID(1)) dutWide (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(wFlush),
        .in_valid_i(wInValid), .in_ready_o(wInReady),
        .WB_i(wWbIn), .MEM_i(wMemIn), .ALUOut_i(wAluIn), .RTData_i(wRtIn), .RD_i(wRdIn),
        .out_valid_o(wOutValid), .out_ready_i(wOutReady),
        .WB_o(wWbOut), .ALUOut_o(wAluOut), .RTData_o(wRtOut), .RD_o(wRdOut),
        .MemRead_o(wMemRead), .MemWrite_o(wMemWrite), .occupancy_o(wOcc));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] wb, input logic [1:0] mem,
                                 input logic [31:0] alu, input logic [4:0] rd);
        s1InValid = valid;
        s1WbIn    = wb;
        s1MemIn   = mem;
        s1AluIn   = alu;
        s1RtIn    = alu ^ 32'hFFFF_0000;
        s1RdIn    = rd;
    endtask

    task automatic stepClock();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] streamVals [3];
        streamVals[0] = 32'h10;
        streamVals[1] = 32'h20;
        streamVals[2] = 32'h30;

        #1;
        checkOutput("rst s1 in_ready", s1InReady, 1);
        checkOutput("rst s1 out_valid", s1OutValid, 0);
        checkOutput("rst s1 occupancy", s1Occ, 0);
        checkOutput("rst s1 ALUOut", s1AluOut, 0);
        checkOutput("rst s0 in_ready", s0InReady, 1);
        checkOutput("rst w in_ready", wInReady, 1);
        stepClock();
        stepClock();
        rst_i = 1'b0;

        // Streaming with downstream always ready
        s1OutReady = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 2'b01, 2'b01, streamVals[i], 5'd1);
            stepClock();
            checkOutput($sformatf("stream ALUOut %0d", i), s1AluOut, streamVals[i]);
            checkOutput($sformatf("stream MemRead %0d", i), s1MemRead, 1);
            checkOutput($sformatf("stream occupancy %0d", i), s1Occ, 1);
            checkOutput($sformatf("stream in_ready %0d", i), s1InReady, 1);
        end
        applyStimulus(0, 2'b00, 2'b00, 32'h0, 5'd0);
        stepClock();
        checkOutput("stream drain valid", s1OutValid, 0);
        checkOutput("stream drain MemRead", s1MemRead, 0);
        checkOutput("stream drain ALUOut kept", s1AluOut, 32'h30);

        // Stall fills head then skid; release in order
        s1OutReady = 0;
        applyStimulus(1, 2'b11, 2'b00, 32'hA0, 5'd3);
        stepClock();
        checkOutput("stall A occupancy", s1Occ, 1);
        checkOutput("stall A in_ready", s1InReady, 1);
        applyStimulus(1, 2'b10, 2'b00, 32'hB0, 5'd7);
        stepClock();
        checkOutput("stall B occupancy", s1Occ, 2);
        checkOutput("stall B in_ready", s1InReady, 0);
        checkOutput("stall B RD held", s1RdOut, 3);
        applyStimulus(1, 2'b01, 2'b01, 32'hC0, 5'd9);
        stepClock();
        checkOutput("stall hold RD", s1RdOut, 3);
        checkOutput("stall hold WB", s1WbOut, 2'b11);
        checkOutput("stall hold occupancy", s1Occ, 2);
        applyStimulus(0, 2'b00, 2'b00, 32'h0, 5'd0);
        s1OutReady = 1;
        stepClock();
        checkOutput("release1 RD", s1RdOut, 7);
        checkOutput("release1 WB", s1WbOut, 2'b10);
        checkOutput("release1 in_ready", s1InReady, 1);
        checkOutput("release1 occupancy", s1Occ, 1);
        stepClock();
        checkOutput("release2 valid", s1OutValid, 0);
        checkOutput("release2 occupancy", s1Occ, 0);

        // Flush with a simultaneous accept
        s1OutReady = 0;
        applyStimulus(1, 2'b01, 2'b10, 32'hAA, 5'd9);
        stepClock();
        checkOutput("flush pre MemWrite", s1MemWrite, 1);
        applyStimulus(1, 2'b11, 2'b10, 32'hBB, 5'd12);
        s1Flush = 1;
        stepClock();
        checkOutput("flush valid", s1OutValid, 0);
        checkOutput("flush MemWrite", s1MemWrite, 0);
        checkOutput("flush WB", s1WbOut, 0);
        checkOutput("flush occupancy", s1Occ, 0);
        checkOutput("flush ALUOut kept", s1AluOut, 32'hAA);
        s1Flush = 0;
        applyStimulus(0, 2'b00, 2'b00, 32'h0, 5'd0);
        s1OutReady = 1;
        stepClock();
        checkOutput("flush after valid", s1OutValid, 0);

        // Single-entry mode: ready follows out_ready_i combinationally
        s0OutReady = 0;
        s0InValid = 1; s0RdIn = 5'd4; s0MemIn = 2'b01; s0WbIn = 2'b10; s0AluIn = 32'h44;
        #1;
        checkOutput("s0 empty in_ready", s0InReady, 1);
        stepClock();
        checkOutput("s0 A RD", s0RdOut, 4);
        checkOutput("s0 A MemRead", s0MemRead, 1);
        s0RdIn = 5'd6; s0AluIn = 32'h66; s0MemIn = 2'b10;
        #1;
        checkOutput("s0 stall in_ready", s0InReady, 0);
        stepClock();
        checkOutput("s0 stall RD held", s0RdOut, 4);
        checkOutput("s0 stall occupancy", s0Occ, 1);
        s0OutReady = 1;
        #1;
        checkOutput("s0 ready follows", s0InReady, 1);
        stepClock();
        checkOutput("s0 B RD", s0RdOut, 6);
        checkOutput("s0 B ALUOut", s0AluOut, 32'h66);
        checkOutput("s0 B MemWrite", s0MemWrite, 1);
        checkOutput("s0 B occupancy", s0Occ, 1);
        s0InValid = 0;
        stepClock();
        checkOutput("s0 drain valid", s0OutValid, 0);
        checkOutput("s0 drain MemWrite", s0MemWrite, 0);
        checkOutput("s0 drain occupancy", s0Occ, 0);

        // Wide fields pass through intact
        wOutReady = 1;
        wInValid = 1; wAluIn = 64'hDEAD_BEEF_0123_4567; wRtIn = 64'hFEDC_BA98_7654_3210;
        wRdIn = 6'd45; wWbIn = 3'b101; wMemIn = 2'b10;
        stepClock();
        wInValid = 0;
        checkOutput("wide ALUOut", wAluOut, 64'hDEAD_BEEF_0123_4567);
        checkOutput("wide RTData", wRtOut, 64'hFEDC_BA98_7654_3210);
        checkOutput("wide RD", wRdOut, 45);
        checkOutput("wide WB", wWbOut, 3'b101);
        checkOutput("wide MemWrite", wMemWrite, 1);
        stepClock();
        checkOutput("wide drain valid", wOutValid, 0);

        // Asynchronous reset while two entries are stalled
        s1OutReady = 0;
        applyStimulus(1, 2'b11, 2'b10, 32'h55, 5'd2);
        stepClock();
        applyStimulus(1, 2'b11, 2'b10, 32'h66, 5'd8);
        stepClock();
        applyStimulus(0, 2'b00, 2'b00, 32'h0, 5'd0);
        checkOutput("pre-rst occupancy", s1Occ, 2);
        #2;
        rst_i = 1;
        #1;
        checkOutput("rst mid valid", s1OutValid, 0);
        checkOutput("rst mid WB", s1WbOut, 0);
        checkOutput("rst mid MemWrite", s1MemWrite, 0);
        checkOutput("rst mid occupancy", s1Occ, 0);
        checkOutput("rst mid in_ready", s1InReady, 1);
        applyStimulus(1, 2'b01, 2'b00, 32'h77, 5'd5);
        #1;
        rst_i = 0;
        stepClock();
        checkOutput("post-rst valid", s1OutValid, 1);
        checkOutput("post-rst RD", s1RdOut, 5);
        checkOutput("post-rst WB", s1WbOut, 2'b01);
        checkOutput("post-rst occupancy", s1Occ, 1);
        applyStimulus(0, 2'b00, 2'b00, 32'h0, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
